// File: rtl/neopixel_dma_ctrl.sv
// SRAM-to-colour-FIFO sequencer: single-outstanding OBI reader feeding the NeoPixel FIFO.
// Optional continuous refresh when NEOPIXEL_DMA_LOOP_EN is defined.
module neopixel_dma_ctrl #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int CntWidth  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [AddrWidth-1:0]   cfg_src_addr_i,
   input  logic [CntWidth-1:0]    cfg_num_bytes_i,
   input  logic                   cfg_valid_i,
   output logic                   obi_req_o,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   input  logic                   obi_gnt_i,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic                   obi_err_i,
   output logic                   obi_rready_o,
   input  logic                   fifo_full_i,
   output logic                   fifo_push_o,
   output logic [DataWidth-1:0]   fifo_data_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_PUSH = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]           state;
   logic                 valid_prev;
   logic [AddrWidth-1:0] cur_addr;
   logic [CntWidth:0]    rem_words;
   logic [DataWidth-1:0] hold_data;
   logic                 err_flag;
   logic                 abort_pend;
   logic                 start;
   logic [CntWidth:0]    words_calc;
`ifdef NEOPIXEL_DMA_LOOP_EN
   logic [AddrWidth-1:0] base_addr;
   logic [CntWidth:0]    total_words;
`endif

   assign start      = cfg_valid_i & ~valid_prev;
   assign words_calc = ({1'b0, cfg_num_bytes_i} + (CntWidth+1)'(3)) >> 2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         valid_prev <= 1'b0;
         cur_addr   <= '0;
         rem_words  <= '0;
         hold_data  <= '0;
         err_flag   <= 1'b0;
         abort_pend <= 1'b0;
`ifdef NEOPIXEL_DMA_LOOP_EN
         base_addr   <= '0;
         total_words <= '0;
`endif
      end else begin
         valid_prev <= cfg_valid_i;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_flag   <= 1'b0;
                  abort_pend <= 1'b0;
                  cur_addr   <= cfg_src_addr_i;
                  rem_words  <= words_calc;
`ifdef NEOPIXEL_DMA_LOOP_EN
                  base_addr   <= cfg_src_addr_i;
                  total_words <= words_calc;
`endif
                  if (cfg_src_addr_i[1:0] != 2'b00) begin
                     err_flag <= 1'b1;
                     state    <= S_ERR;
                  end else if (words_calc == '0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               // A grant coinciding with the abort still owes us a response.
               if (obi_gnt_i) begin
                  abort_pend <= ~cfg_valid_i;
                  state      <= S_RESP;
               end else if (!cfg_valid_i) begin
                  state <= S_IDLE;
               end
            end
            S_RESP: begin
               if (!cfg_valid_i) begin
                  abort_pend <= 1'b1;
               end
               if (obi_rvalid_i) begin
                  if (abort_pend || !cfg_valid_i) begin
                     state <= S_IDLE;
                  end else if (obi_err_i) begin
                     err_flag <= 1'b1;
                     state    <= S_ERR;
                  end else begin
                     hold_data <= obi_rdata_i;
                     state     <= S_PUSH;
                  end
               end
            end
            S_PUSH: begin
               if (!cfg_valid_i) begin
                  state <= S_IDLE;
               end else if (!fifo_full_i) begin
                  cur_addr  <= cur_addr + AddrWidth'(4);
                  rem_words <= rem_words - (CntWidth+1)'(1);
                  if (rem_words == (CntWidth+1)'(1)) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_DONE: begin
`ifdef NEOPIXEL_DMA_LOOP_EN
               if (cfg_valid_i && total_words != '0) begin
                  cur_addr  <= base_addr;
                  rem_words <= total_words;
                  state     <= S_REQ;
               end else begin
                  state <= S_IDLE;
               end
`else
               state <= S_IDLE;
`endif
            end
            S_ERR: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Byte enables are only driven while requesting so every output idles at zero.
   assign obi_req_o    = (state == S_REQ);
   assign obi_addr_o   = cur_addr;
   assign obi_we_o     = 1'b0;
   assign obi_be_o     = obi_req_o ? '1 : '0;
   assign obi_rready_o = (state == S_RESP);
   assign fifo_push_o  = (state == S_PUSH) & ~fifo_full_i & cfg_valid_i;
   assign fifo_data_o  = hold_data;
   assign busy_o       = (state == S_REQ) | (state == S_RESP) | (state == S_PUSH);
   assign done_o       = (state == S_DONE);
   assign err_o        = err_flag;

endmodule

// File: tb/tb_neopixel_dma_ctrl.sv
// Self-checking bench for neopixel_dma_ctrl: OBI memory model, expected address/data
// queues built from the transfer parameters, and per-cycle output checks.
module tb_neopixel_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst_i, cfg_valid_i, obi_req_o, obi_we_o, obi_gnt_i, obi_rvalid_i;
   logic        obi_err_i, obi_rready_o, fifo_full_i, fifo_push_o, busy_o, done_o, err_o;
   logic [31:0] cfg_src_addr_i, cfg_num_bytes_i, obi_addr_o, obi_rdata_i, fifo_data_o;
   logic [3:0]  obi_be_o;

   always #5 clk = ~clk;

   neopixel_dma_ctrl #(.AddrWidth(32), .DataWidth(32), .CntWidth(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cfg_src_addr_i(cfg_src_addr_i), .cfg_num_bytes_i(cfg_num_bytes_i), .cfg_valid_i(cfg_valid_i),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
      .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
      .obi_err_i(obi_err_i), .obi_rready_o(obi_rready_o),
      .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [31:0] exp_addr[$], exp_data[$];
   int grants, pushes, dones = 0, done_cyc, start_cyc, d_before;
   int grant_cyc[$], push_cyc[$];
   logic [31:0] last_push_data, last_grant_addr;
   bit pending = 0;
   logic [31:0] pend_addr;
   int lat, resp_idx, err_idx = -1, gnt_mode = 0, min_lat = 0, max_lat = 0;
   logic s_valid = 0, s_rst = 1, s_full = 0;
   logic [31:0] s_src = 0, s_bytes = 0;
   bit full_rand = 0, prev_req_wait = 0, prev_done = 0;
   logic [31:0] prev_addr;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: apply stimulus at negedge, play the OBI memory, then check.
   task automatic step();
      @(negedge clk);
      rst_i = s_rst; cfg_valid_i = s_valid; cfg_src_addr_i = s_src; cfg_num_bytes_i = s_bytes;
      fifo_full_i = full_rand ? ($urandom_range(0, 2) == 0) : s_full;
      obi_gnt_i = obi_req_o && !pending &&
                  (gnt_mode == 0 || (gnt_mode == 1 && $urandom_range(0, 2) != 0));
      if (pending && lat == 0) begin
         obi_rvalid_i = 1'b1; obi_rdata_i = mem_word(pend_addr); obi_err_i = (resp_idx == err_idx);
      end else begin
         obi_rvalid_i = 1'b0; obi_rdata_i = $urandom; obi_err_i = 1'b0;
         if (pending) lat--;
      end
      #1;
      cyc++;
      chk("we_low", obi_we_o, 0);
      if (obi_req_o) begin
         chk("be_ones", obi_be_o, 4'hf);
         chk("one_outstanding", pending, 0);
      end
      if (obi_req_o && prev_req_wait) chk("addr_stable", obi_addr_o, prev_addr);
      if (obi_req_o || obi_rready_o || fifo_push_o) chk("busy_active", busy_o, 1);
      if (done_o) begin
         chk("busy_in_done", busy_o, 0);
         chk("done_single_cycle", prev_done, 0);
      end
      if (fifo_push_o) chk("push_not_full", fifo_full_i, 0);
      if (!rst_i) begin
         if (obi_req_o && obi_gnt_i) begin
            grants++; grant_cyc.push_back(cyc); last_grant_addr = obi_addr_o;
            chk("req_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("req_addr", obi_addr_o, exp_addr.pop_front());
            pending = 1; pend_addr = obi_addr_o; lat = $urandom_range(min_lat, max_lat);
         end
         if (obi_rvalid_i && obi_rready_o) begin
            pending = 0; resp_idx++;
         end
         if (fifo_push_o) begin
            pushes++; push_cyc.push_back(cyc); last_push_data = fifo_data_o;
            chk("push_expected", exp_data.size() > 0, 1);
            if (exp_data.size() > 0) chk("push_data", fifo_data_o, exp_data.pop_front());
         end
         if (done_o) begin
            dones++; done_cyc = cyc;
         end
      end else begin
         pending = 0;
      end
      prev_req_wait = obi_req_o && !obi_gnt_i && !rst_i;
      prev_addr = obi_addr_o;
      prev_done = done_o;
   endtask

   task automatic idle(int n);
      s_valid = 0;
      repeat (n) step();
   endtask

   task automatic start_xfer(logic [31:0] src, logic [31:0] bytes);
      longint unsigned w;
      logic [31:0] a;
      w = (longint'(bytes) + 3) >> 2;
      exp_addr.delete(); exp_data.delete(); grant_cyc.delete(); push_cyc.delete();
      grants = 0; pushes = 0; resp_idx = 0; d_before = dones;
      if (src[1:0] == 2'b00)
         for (longint unsigned i = 0; i < w; i++) begin
            a = src + 32'(4 * i);
            exp_addr.push_back(a); exp_data.push_back(mem_word(a));
         end
      s_src = src; s_bytes = bytes; s_valid = 1;
      step();
      start_cyc = cyc;
   endtask

   task automatic wait_end(int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if ((dones != d_before || err_o) && !busy_o) begin
            ok = 1;
            break;
         end
      end
      chk("end_within_budget", ok, 1);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_req"}, obi_req_o, 0);     chk({tag, "_addr"}, obi_addr_o, 0);
      chk({tag, "_be"}, obi_be_o, 0);       chk({tag, "_rready"}, obi_rready_o, 0);
      chk({tag, "_push"}, fifo_push_o, 0);  chk({tag, "_data"}, fifo_data_o, 0);
      chk({tag, "_busy"}, busy_o, 0);       chk({tag, "_done"}, done_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   initial begin
      logic [31:0] src, bytes, words;
      bit seen;
      repeat (3) step();
      chk_all_zero("reset");
      s_rst = 0;
      step();

      // 12 bytes, immediate slave: 3 words at 3 cycles each.
      start_xfer(32'h1000_0000, 12);
      wait_end(60);
      chk("t1_grants", grants, 3);
      chk("t1_pushes", pushes, 3);
      chk("t1_done", dones - d_before, 1);
      chk("t1_first_grant_cyc", grant_cyc[0] - start_cyc, 1);
      chk("t1_last_push_cyc", push_cyc[2] - start_cyc, 9);
      chk("t1_done_cyc", done_cyc - start_cyc, 10);
      chk("t1_last_addr", last_grant_addr, 32'h1000_0008);
      chk("t1_last_data", last_push_data, 32'h135f_7420);
      repeat (6) step();
      chk("t1_level_no_restart", grants, 3);
      chk("t1_busy_after", busy_o, 0);

      // 5 bytes -> 2 words; 0 bytes -> done only.
      idle(2);
      start_xfer(32'h2000_0000, 5);
      wait_end(60);
      chk("t2_grants", grants, 2);
      chk("t2_pushes", pushes, 2);
      chk("t2_done", dones - d_before, 1);
      idle(2);
      start_xfer(32'h2000_0100, 0);
      wait_end(20);
      chk("t3_grants", grants, 0);
      chk("t3_done", dones - d_before, 1);
      chk("t3_done_cyc", done_cyc - start_cyc, 1);

      // FIFO full for 10 cycles while the second word waits.
      idle(2);
      start_xfer(32'h3000_0000, 12);
      repeat (4) step();
      s_full = 1;
      repeat (10) step();
      s_full = 0;
      wait_end(60);
      chk("t4_pushes", pushes, 3);
      chk("t4_push2_cyc", push_cyc[1] - start_cyc, 15);
      chk("t4_grant3_cyc", grant_cyc[2] - start_cyc, 16);
      chk("t4_done_cyc", done_cyc - start_cyc, 19);

      // Bus error on the second response, then a clean restart.
      idle(2);
      gnt_mode = 1; max_lat = 2; err_idx = 1;
      start_xfer(32'h4000_0000, 16);
      wait_end(100);
      repeat (5) step();
      chk("t5_err", err_o, 1);
      chk("t5_grants", grants, 2);
      chk("t5_pushes", pushes, 1);
      chk("t5_no_done", dones - d_before, 0);
      err_idx = -1;
      idle(2);
      start_xfer(32'h4100_0000, 4);
      step();
      chk("t5_err_cleared", err_o, 0);
      wait_end(100);
      chk("t5_restart_pushes", pushes, 1);
      gnt_mode = 0; max_lat = 0;

      // Misaligned source; address wrap.
      idle(2);
      start_xfer(32'h1000_0002, 8);
      wait_end(20);
      chk("t6_err", err_o, 1);
      chk("t6_grants", grants, 0);
      chk("t6_no_done", dones - d_before, 0);
      idle(2);
      start_xfer(32'hffff_fff8, 12);
      wait_end(60);
      chk("t7_grants", grants, 3);
      chk("t7_wrap_addr", last_grant_addr, 32'h0000_0000);
      chk("t7_err", err_o, 0);

      // Abort while waiting on a response.
      idle(2);
      min_lat = 4; max_lat = 4;
      start_xfer(32'h5000_0000, 8);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         seen = obi_rready_o;
      end
      chk("t8_reached_resp", seen, 1);
      s_valid = 0;
      repeat (10) step();
      chk("t8_resp_consumed", pending, 0);
      chk("t8_no_push", pushes, 0);
      chk("t8_no_done", dones - d_before, 0);
      chk("t8_no_err", err_o, 0);
      chk("t8_idle", busy_o, 0);
      min_lat = 0; max_lat = 0;

      // Reset while a request is pending.
      idle(2);
      gnt_mode = 2;
      start_xfer(32'h6000_0000, 8);
      repeat (3) step();
      chk("t9_in_req", obi_req_o, 1);
      s_rst = 1; s_valid = 0;
      step();
      step();
      chk_all_zero("t9_reset");
      s_rst = 0; gnt_mode = 0;
      step();

      // Randomised transfers with random grant, latency and FIFO back-pressure.
      gnt_mode = 1; max_lat = 3; full_rand = 1;
      for (int k = 0; k < 25; k++) begin
         src = $urandom;
         src[1:0] = 2'b00;
         if ($urandom_range(0, 3) == 0) src = 32'hffff_ffe0 | (src & 32'h1c);
         bytes = $urandom_range(0, 40);
         words = (bytes + 3) >> 2;
         idle(2);
         start_xfer(src, bytes);
         wait_end(1500);
         chk("rnd_done", dones - d_before, 1);
         chk("rnd_grants", grants, words);
         chk("rnd_pushes", pushes, words);
         chk("rnd_err", err_o, 0);
         chk("rnd_data_drained", exp_data.size(), 0);
      end
      full_rand = 0;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/neopixel_dma_ctrl.md
Name: neopixel_dma_ctrl

Overview:
Sequencer that moves pixel colour words from SRAM into the NeoPixel colour FIFO. It is configured by the DMA register bank (source address, byte count, valid). It acts as a single-outstanding OBI read manager on the user-domain crossbar. It pushes each returned word into the colour FIFO and back-pressures on FIFO full.

Parameters:
AddrWidth, 32, OBI address width
DataWidth, 32, OBI data width and FIFO word width
CntWidth, 32, width of the byte-count register

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_src_addr_i  in  AddrWidth  DMA_SRC_ADDR register
cfg_num_bytes_i  in  CntWidth  DMA_NUM_BYTES register
cfg_valid_i  in  1  DMA_VALID register bit 0
obi_req_o  out  1  OBI request
obi_addr_o  out  AddrWidth  OBI address
obi_we_o  out  1  write enable, always 0
obi_be_o  out  DataWidth/8  byte enables, always all ones
obi_gnt_i  in  1  OBI grant
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  DataWidth  OBI read data
obi_err_i  in  1  OBI response error
obi_rready_o  out  1  response ready
fifo_full_i  in  1  colour FIFO full
fifo_push_o  out  1  FIFO write strobe
fifo_data_o  out  DataWidth  FIFO write data
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  sticky error flag, cleared on next start

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, edge detector history = 0.
  - Synchronous reset mid-transfer returns to IDLE immediately, even with a request pending.
  - This is a system-level reset only, so the OBI protocol violation is accepted.
- Start condition: rising edge of cfg_valid_i, detected against the value registered the previous cycle.
  - A level held high does not restart.
  - On start, the block latches the source address, computes word count = (num_bytes + 3) >> 2 in CntWidth+1 bits, and clears err_o.
- Start checks:
  - cfg_src_addr_i[1:0] != 0: go to ERR, set err_o, no bus traffic.
  - num_bytes == 0: pulse done_o the next cycle, busy_o never asserts.
- FSM states:
  - IDLE: waits for the start condition.
  - REQ: obi_req_o=1; addr and be stay stable until obi_gnt_i. On grant go to RESP.
  - RESP: obi_rready_o=1; wait for obi_rvalid_i.
    - err_i=1: go to ERR.
    - Otherwise latch rdata into the holding register and go to PUSH.
  - PUSH: when !fifo_full_i, assert fifo_push_o for exactly one cycle with the held data.
    - Then increment the address by 4 (modulo 2^AddrWidth, wrap permitted) and decrement the remaining count.
    - If remaining count hits 0, go to DONE; else go to REQ.
  - DONE: done_o=1 for one cycle, then IDLE.
  - ERR: err_o=1 (sticky), then IDLE.
- busy_o = 1 in REQ, RESP and PUSH.
- OBI rules:
  - At most one outstanding transaction.
  - CombGnt=0: rvalid arrives no earlier than the cycle after gnt.
  - The request is never dropped before grant.
- Abort: cfg_valid_i falling while busy.
  - An ungranted REQ returns to IDLE.
  - A pending RESP completes the bus response, discards the data, and returns to IDLE.
  - No done_o is issued and err_o is not set.
- Last word of a non-multiple-of-4 byte count is pushed as a full word; the consumer ignores surplus bytes.
- Start while busy: a rising edge can only follow a fall, which aborts first; no queuing.
- Throughput: minimum 3 cycles per word (REQ, RESP, PUSH) with immediate gnt/rvalid and a non-full FIFO.

Optional Feature:
NEOPIXEL_DMA_LOOP_EN:
- Defined: after DONE, if cfg_valid_i is still 1, the block reloads the latched start address and word count and re-enters REQ without a new rising edge. This gives continuous animation refresh. done_o still pulses once per pass.
- Undefined: DONE always returns to IDLE, and a new rising edge is required.

Test Plan:
- src=0x1000_0000, bytes=12, valid 0->1, immediate gnt/rvalid, FIFO empty -> reads at 0x..00/04/08, 3 pushes with matching data, done_o one pulse, busy_o low afterwards.
- bytes=5 -> exactly 2 reads and 2 pushes; bytes=0 -> no obi_req_o, done_o pulses once.
- fifo_full_i held high for 10 cycles during the second word -> fifo_push_o stays 0, no third request issued, push occurs the cycle after full drops.
- obi_err_i=1 on the second response -> err_o=1, no further requests, done_o never pulses; next valid 0->1 clears err_o.
- src=0x1000_0002 -> err_o=1 with zero bus activity; src=0xFFFF_FFF8, bytes=12 -> addresses FFF8, FFFC, 0000.
- valid dropped while in RESP -> response consumed, no push, IDLE; reset asserted in REQ -> all outputs 0 the next cycle.
